// File: rtl/key_loader.sv
// Purpose : receives a serial key frame plus even parity and commits it once to the key
//           inputs of the locked core; a decoy key is driven until a commit succeeds.
// Latency : KEY_W data-bit cycles, one parity cycle, one commit cycle; D and KEY_LOCKED
//           update at the clock edge that ends the commit cycle.
// Backpressure: KEY_RDY is high only in SHIFT/PARITY, and KEY_VLD low stalls indefinitely.
//           LOCKED and LOCKOUT are terminal until RST.
//
// Ports: CLK/RST (async active-high) | LOAD_START starts a frame | KEY_SI/KEY_VLD/KEY_RDY
//        carry serial key bits MSB first, then parity | D drives the key | KEY_LOCKED,
//        KEY_ERR, LOCKOUT and TRY_CNT report status.
module key_loader #(
    parameter int                KEY_W     = 2,
    parameter int                MAX_TRY   = 3,
    parameter logic [KEY_W-1:0]  DECOY_KEY = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_START,
    input  logic             KEY_SI,
    input  logic             KEY_VLD,
    output logic             KEY_RDY,
    output logic [KEY_W-1:0] D,
    output logic             KEY_LOCKED,
    output logic             KEY_ERR,
    output logic             LOCKOUT,
    output logic [3:0]       TRY_CNT
);

    // The counter only has to reach KEY_W-1: the last data bit moves the FSM to PARITY.
    localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_COMMIT,
        S_LOCKED,
        S_LOCKOUT
    } state_t;

    state_t           state, state_nxt;
    logic [KEY_W-1:0] sreg;
    logic [KEY_W-1:0] d_reg;
    logic [CW-1:0]    bit_cnt;
    logic             key_locked;
    logic             key_err;
    logic [3:0]       try_cnt;

    logic             frame_clr;
    logic             shift_en;
    logic             frame_fail;
    logic             parity_ok;
    logic [3:0]       try_nxt;

    // Even parity across key bits and the parity bit.
    assign parity_ok = ~((^sreg) ^ KEY_SI);

    // The lockout transition happens at MAX_TRY, so saturation only guards against
    // an unreachable overflow.
    assign try_nxt = (try_cnt < 4'(MAX_TRY)) ? try_cnt + 4'd1 : try_cnt;

    always_comb begin
        state_nxt  = state;
        frame_clr  = 1'b0;
        shift_en   = 1'b0;
        frame_fail = 1'b0;
        case (state)
            S_IDLE: begin
                // A KEY_VLD in the same cycle as LOAD_START is dropped on purpose.
                if (LOAD_START) begin
                    state_nxt = S_SHIFT;
                    frame_clr = 1'b1;
                end
            end
            S_SHIFT: begin
                if (KEY_VLD) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CW'(KEY_W - 1)) begin
                        state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (KEY_VLD) begin
                    if (parity_ok) begin
                        state_nxt = S_COMMIT;
                    end else begin
                        frame_fail = 1'b1;
                        state_nxt  = (try_nxt >= 4'(MAX_TRY)) ? S_LOCKOUT : S_IDLE;
                    end
                end
            end
            S_COMMIT:  state_nxt = S_LOCKED;
            S_LOCKED:  state_nxt = S_LOCKED;
            S_LOCKOUT: state_nxt = S_LOCKOUT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The shift register is kept separate from d_reg so D is stable while a frame arrives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            d_reg      <= DECOY_KEY;
            key_locked <= 1'b0;
            key_err    <= 1'b0;
            try_cnt    <= 4'd0;
        end else begin
            if (frame_clr) begin
                sreg    <= '0;
                bit_cnt <= '0;
                key_err <= 1'b0;
            end
            if (shift_en) begin
                sreg    <= (sreg << 1) | KEY_W'(KEY_SI);
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (frame_fail) begin
                key_err <= 1'b1;
                try_cnt <= try_nxt;
            end
            if (state == S_COMMIT) begin
                d_reg      <= sreg;
                key_locked <= 1'b1;
            end
        end
    end

    assign KEY_RDY    = (state == S_SHIFT) || (state == S_PARITY);
    assign LOCKOUT    = (state == S_LOCKOUT);
    assign D          = (state == S_LOCKOUT) ? DECOY_KEY : d_reg;
    assign KEY_LOCKED = key_locked;
    assign KEY_ERR    = key_err;
    assign TRY_CNT    = try_cnt;

endmodule

// File: tb/tb_key_loader.sv
// Purpose : scoreboard bench for key_loader with KEY_W=2, MAX_TRY=3 and a zero decoy key.
// Latency : inputs are driven at negedges and outputs are sampled at negedges; a good frame
//           commits two edges after the parity edge.
// Backpressure: KEY_RDY is checked against a reference model before each data bit is driven.
module tb_key_loader;

    localparam int               KEY_W   = 2;
    localparam int               MAX_TRY = 3;
    localparam logic [KEY_W-1:0] DECOY   = 2'b00;

    logic             CLK = 1'b0;
    logic             RST;
    logic             LOAD_START;
    logic             KEY_SI;
    logic             KEY_VLD;
    logic             KEY_RDY;
    logic [KEY_W-1:0] D;
    logic             KEY_LOCKED;
    logic             KEY_ERR;
    logic             LOCKOUT;
    logic [3:0]       TRY_CNT;

    key_loader #(.KEY_W(KEY_W), .MAX_TRY(MAX_TRY), .DECOY_KEY(DECOY)) dut (
        .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .KEY_SI(KEY_SI),
        .KEY_VLD(KEY_VLD), .KEY_RDY(KEY_RDY), .D(D), .KEY_LOCKED(KEY_LOCKED),
        .KEY_ERR(KEY_ERR), .LOCKOUT(LOCKOUT), .TRY_CNT(TRY_CNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // The reference model of the loader's externally visible state.
    logic [KEY_W-1:0] m_d;
    logic             m_locked;
    logic             m_err;
    logic [3:0]       m_try;
    logic             m_lockout;
    logic [KEY_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic model_reset();
        m_d       = DECOY;
        m_locked  = 1'b0;
        m_err     = 1'b0;
        m_try     = 4'd0;
        m_lockout = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".D"},       32'(D),          32'(m_d));
        chk({tag, ".locked"},  32'(KEY_LOCKED), 32'(m_locked));
        chk({tag, ".err"},     32'(KEY_ERR),    32'(m_err));
        chk({tag, ".try"},     32'(TRY_CNT),    32'(m_try));
        chk({tag, ".lockout"}, 32'(LOCKOUT),    32'(m_lockout));
        chk({tag, ".rdy"},     32'(KEY_RDY),    32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        model_reset();
    endtask

    // Sends one frame. stall inserts idle cycles after the first bit, mid_start pulses
    // LOAD_START inside the frame, and vld_on_start raises KEY_VLD with KEY_SI=1 during
    // the start cycle. That bit must not be captured.
    task automatic do_frame(input string tag, input logic [KEY_W-1:0] key, input logic p,
                            input int stall, input bit mid_start, input bit vld_on_start);
        logic active;
        logic good;
        active = !m_locked && !m_lockout;
        good   = ~((^key) ^ p);

        LOAD_START = 1'b1;
        KEY_VLD    = vld_on_start;
        KEY_SI     = 1'b1;
        step();
        LOAD_START = 1'b0;
        KEY_VLD    = 1'b0;

        for (int i = 0; i < KEY_W; i++) begin
            chk({tag, ".rdy_bit"}, 32'(KEY_RDY), 32'(active));
            chk({tag, ".D_hold"},  32'(D),       32'(m_d));
            KEY_SI  = key[KEY_W-1-i];
            KEY_VLD = 1'b1;
            step();
            KEY_VLD = 1'b0;
            if (i == 0) begin
                repeat (stall) step();
                if (mid_start) begin
                    LOAD_START = 1'b1;
                    step();
                    LOAD_START = 1'b0;
                end
            end
        end

        chk({tag, ".rdy_par"}, 32'(KEY_RDY), 32'(active));
        KEY_SI  = p;
        KEY_VLD = 1'b1;
        step();
        KEY_VLD = 1'b0;

        if (active) begin
            if (good) begin
                exp_q.push_back(key);
            end else begin
                m_err = 1'b1;
                if (m_try < 4'(MAX_TRY)) m_try = m_try + 4'd1;
                if (m_try == 4'(MAX_TRY)) m_lockout = 1'b1;
            end
        end

        step();  // the commit cycle has ended by this point
        if (exp_q.size() > 0) begin
            chk({tag, ".commit_lat"}, 32'(KEY_LOCKED), 32'd1);
            m_d      = exp_q.pop_front();
            m_locked = 1'b1;
            m_err    = 1'b0;
            chk({tag, ".commit_D"}, 32'(D), 32'(m_d));
        end
        check_status(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; LOAD_START = 1'b0; KEY_SI = 1'b0; KEY_VLD = 1'b0;
        model_reset();
        step();
        check_status("reset");
        step();
        RST = 1'b0;
        step();

        // A good load, followed by a frame that the committed loader must ignore.
        do_frame("good", 2'b10, 1'b1, 0, 1'b0, 1'b0);
        do_frame("post_commit", 2'b01, 1'b1, 0, 1'b0, 1'b0);

        // A bad frame leaves KEY_ERR set through IDLE. A retry then commits, and its start
        // cycle also raises KEY_VLD.
        do_reset();
        do_frame("bad1", 2'b11, 1'b1, 0, 1'b0, 1'b0);
        repeat (3) step();
        chk("err_sticky", 32'(KEY_ERR), 32'd1);
        do_frame("retry", 2'b01, 1'b1, 0, 1'b0, 1'b1);

        // Three bad frames lock the loader out, and a fourth good frame is ignored.
        do_reset();
        do_frame("lo1", 2'b11, 1'b1, 0, 1'b0, 1'b0);
        do_frame("lo2", 2'b00, 1'b1, 0, 1'b0, 1'b0);
        do_frame("lo3", 2'b10, 1'b0, 0, 1'b0, 1'b0);
        do_frame("lo4", 2'b10, 1'b1, 0, 1'b0, 1'b0);

        // A frame with a five-cycle stall and an ignored mid-frame LOAD_START.
        do_reset();
        do_frame("stall", 2'b11, 1'b0, 5, 1'b1, 1'b0);

        // An asynchronous reset between bit 1 and bit 2, then a fresh frame.
        do_reset();
        LOAD_START = 1'b1;
        step();
        LOAD_START = 1'b0;
        KEY_SI = 1'b1; KEY_VLD = 1'b1;
        step();
        KEY_VLD = 1'b0;
        chk("pre_rst.rdy", 32'(KEY_RDY), 32'd1);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_status("async_rst");
        step();
        RST = 1'b0;
        step();
        do_frame("after_rst", 2'b01, 1'b1, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
